// File: rtl/simm_port_arbiter_if.sv
// Requester and DRAM-controller signal bundle for simm_port_arbiter.
// slave is the arbiter's view; master is the requesters plus controller.
interface simm_port_arbiter_if #(
  parameter int NPORTS = 4
);
  logic [NPORTS-1:0]    req;
  logic [NPORTS-1:0]    we;
  logic [NPORTS*24-1:0] addr;
  logic [NPORTS*8-1:0]  wdata;
  logic [NPORTS-1:0]    ack;
  logic                 err;
  logic [7:0]           rdata;
  logic [2:0]           grant_id;
  logic                 busy;
  logic                 mem_ena;
  logic                 mem_write;
  logic [23:0]          mem_addr;
  logic [7:0]           mem_wdata;
  logic                 mem_dtack;
  logic [7:0]           mem_rdata;

  modport master (
    output req, we, addr, wdata, mem_dtack, mem_rdata,
    input  ack, err, rdata, grant_id, busy, mem_ena, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    input  req, we, addr, wdata, mem_dtack, mem_rdata,
    output ack, err, rdata, grant_id, busy, mem_ena, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/simm_port_arbiter.sv
// Round-robin arbiter sharing one SIMM DRAM controller among NPORTS requesters,
// sequencing the ena/dtack handshake with a watchdog abort.
module simm_port_arbiter #(
  parameter int NPORTS  = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  simm_port_arbiter_if.slave bus
);
  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, DRAIN} state_t;

  state_t            state_r, state_s;
  logic              ena_r, ena_s;
  logic              write_r, write_s;
  logic [23:0]       maddr_r, maddr_s;
  logic [7:0]        mwdata_r, mwdata_s;
  logic [NPORTS-1:0] ack_r, ack_s;
  logic              err_r, err_s;
  logic [7:0]        rdata_r, rdata_s;
  logic [PW-1:0]     grant_r, grant_s;
  logic [PW-1:0]     ptr_r, ptr_s;
  logic [WW-1:0]     wdog_r, wdog_s;
  logic              busy_r;
  logic [PW-1:0]     sel_s;

  logic [23:0] port_addr_s  [NPORTS];
  logic [7:0]  port_wdata_s [NPORTS];

  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    assign port_addr_s[g]  = bus.addr[g*24 +: 24];
    assign port_wdata_s[g] = bus.wdata[g*8 +: 8];
  end

  // First requesting port found scanning ptr, ptr+1, ... wrapping at NPORTS.
  function automatic logic [PW-1:0] pick_port(input logic [NPORTS-1:0] r,
                                               input logic [PW-1:0] p);
    logic [PW-1:0] sel;
    logic [PW-1:0] idx;
    logic          found;
    sel   = p;
    found = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      idx = PW'((int'(p) + i) % NPORTS);
      if (r[idx] && !found) begin
        sel   = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return sel;
  endfunction

  function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
    return PW'((int'(p) + 1) % NPORTS);
  endfunction

  assign sel_s = pick_port(bus.req, ptr_r);

  // Next-state and next-register values for the handshake sequencer.
  always_comb begin
    state_s  = state_r;
    ena_s    = ena_r;
    write_s  = write_r;
    maddr_s  = maddr_r;
    mwdata_s = mwdata_r;
    ack_s    = '0;
    err_s    = 1'b0;
    rdata_s  = rdata_r;
    grant_s  = grant_r;
    ptr_s    = ptr_r;
    wdog_s   = wdog_r;
    case (state_r)
      IDLE: begin
        if (|bus.req) begin
          grant_s  = sel_s;
          maddr_s  = port_addr_s[sel_s];
          write_s  = bus.we[sel_s];
          mwdata_s = port_wdata_s[sel_s];
          ena_s    = 1'b1;
          wdog_s   = '0;
          state_s  = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (bus.mem_dtack) begin
          if (!write_r) begin
            rdata_s = bus.mem_rdata;
          end else begin
            rdata_s = rdata_r;
          end
          ena_s          = 1'b0;
          ack_s[grant_r] = 1'b1;
          ptr_s          = next_port(grant_r);
          state_s        = RELEASE;
        end else if (wdog_r == WW'(TIMEOUT - 1)) begin
          ena_s          = 1'b0;
          ack_s[grant_r] = 1'b1;
          err_s          = 1'b1;
          rdata_s        = 8'h00;
          ptr_s          = next_port(grant_r);
          state_s        = RELEASE;
        end else begin
          wdog_s = wdog_r + WW'(1);
        end
      end
      // A dtack arriving after a watchdog abort is swallowed while waiting here.
      RELEASE, DRAIN: begin
        ena_s = 1'b0;
        if (!bus.mem_dtack) begin
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        ena_s   = 1'b0;
        state_s = DRAIN;
      end
    endcase
  end

  // State and output registers with synchronous reset into DRAIN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= DRAIN;
      ena_r    <= 1'b0;
      write_r  <= 1'b0;
      maddr_r  <= 24'h000000;
      mwdata_r <= 8'h00;
      ack_r    <= '0;
      err_r    <= 1'b0;
      rdata_r  <= 8'h00;
      grant_r  <= '0;
      ptr_r    <= '0;
      wdog_r   <= '0;
      busy_r   <= 1'b1;
    end else begin
      state_r  <= state_s;
      ena_r    <= ena_s;
      write_r  <= write_s;
      maddr_r  <= maddr_s;
      mwdata_r <= mwdata_s;
      ack_r    <= ack_s;
      err_r    <= err_s;
      rdata_r  <= rdata_s;
      grant_r  <= grant_s;
      ptr_r    <= ptr_s;
      wdog_r   <= wdog_s;
      busy_r   <= (state_s != IDLE);
    end
  end

  assign bus.mem_ena   = ena_r;
  assign bus.mem_write = write_r;
  assign bus.mem_addr  = maddr_r;
  assign bus.mem_wdata = mwdata_r;
  assign bus.ack       = ack_r;
  assign bus.err       = err_r;
  assign bus.rdata     = rdata_r;
  assign bus.grant_id  = 3'(grant_r);
  assign bus.busy      = busy_r;
endmodule

// File: tb/tb_simm_port_arbiter.sv
// Directed bench for simm_port_arbiter with a simple DRAM controller model.
module tb_simm_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   dly = 8;
  int   cnt = 0;
  bit   no_dtack = 1'b0;
  bit   force_dtack = 1'b1;

  simm_port_arbiter_if #(.NPORTS(4)) bus ();

  simm_port_arbiter #(.NPORTS(4), .TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Controller model: dtack after dly cycles of mem_ena, low once mem_ena drops.
  always @(posedge clk) begin
    #2;
    if (force_dtack) bus.mem_dtack = 1'b1;
    else if (!bus.mem_ena) begin
      bus.mem_dtack = 1'b0;
      cnt = 0;
    end else if (no_dtack) bus.mem_dtack = 1'b0;
    else if (cnt >= dly) bus.mem_dtack = 1'b1;
    else cnt++;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (|bus.ack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int ena_cnt;
    logic [3:0] exp_ack;
    bus.req = 4'h0;
    bus.we = 4'h0;
    bus.addr = '0;
    bus.wdata = '0;
    bus.mem_rdata = 8'h00;

    // 1: reset with dtack stuck high, then drain
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_ena", 32'(bus.mem_ena), 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    check("rst_grant", 32'(bus.grant_id), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("drain_busy", 32'(bus.busy), 32'd1);
      check("drain_ena", 32'(bus.mem_ena), 32'd0);
    end
    force_dtack = 1'b0;
    wait_idle(5, ok);
    check("drain_exit", 32'(ok), 32'd1);

    // 2: port1 read
    dly = 8;
    bus.mem_rdata = 8'hA5;
    bus.addr[47:24] = 24'h123456;
    bus.we[1] = 1'b0;
    bus.req[1] = 1'b1;
    @(negedge clk);
    check("rd_ena", 32'(bus.mem_ena), 32'd1);
    check("rd_addr", 32'(bus.mem_addr), 32'h123456);
    check("rd_write", 32'(bus.mem_write), 32'd0);
    check("rd_grant", 32'(bus.grant_id), 32'd1);
    wait_ack(40, ok);
    check("rd_ack_seen", 32'(ok), 32'd1);
    check("rd_ack", 32'(bus.ack), 32'b0010);
    check("rd_rdata", 32'(bus.rdata), 32'hA5);
    check("rd_err", 32'(bus.err), 32'd0);
    check("rd_ena_off", 32'(bus.mem_ena), 32'd0);
    bus.req[1] = 1'b0;
    @(negedge clk);
    check("rd_ack_pulse", 32'(bus.ack), 32'd0);
    wait_idle(10, ok);
    check("rd_idle", 32'(ok), 32'd1);

    // 3: all ports requesting, rotation from ptr=0
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_idle(10, ok);
    check("rr_idle", 32'(ok), 32'd1);
    dly = 2;
    bus.mem_rdata = 8'h5A;
    bus.we = 4'h0;
    bus.req = 4'hF;
    for (int k = 0; k < 6; k++) begin
      wait_ack(40, ok);
      check("rr_ack_seen", 32'(ok), 32'd1);
      exp_ack = 4'b0001 << (k % 4);
      check("rr_ack", 32'(bus.ack), 32'(exp_ack));
      check("rr_grant", 32'(bus.grant_id), 32'(k % 4));
      check("rr_err", 32'(bus.err), 32'd0);
    end
    bus.req = 4'h0;
    wait_idle(10, ok);
    check("rr_done_idle", 32'(ok), 32'd1);

    // 4: port2 write leaves rdata alone
    bus.mem_rdata = 8'hFF;
    bus.addr[71:48] = 24'hABCDEF;
    bus.wdata[23:16] = 8'h3C;
    bus.we[2] = 1'b1;
    bus.req[2] = 1'b1;
    @(negedge clk);
    check("wr_write", 32'(bus.mem_write), 32'd1);
    check("wr_wdata", 32'(bus.mem_wdata), 32'h3C);
    check("wr_addr", 32'(bus.mem_addr), 32'hABCDEF);
    check("wr_grant", 32'(bus.grant_id), 32'd2);
    wait_ack(40, ok);
    check("wr_ack_seen", 32'(ok), 32'd1);
    check("wr_ack", 32'(bus.ack), 32'b0100);
    check("wr_rdata", 32'(bus.rdata), 32'h5A);
    bus.req[2] = 1'b0;
    bus.we[2] = 1'b0;
    wait_idle(10, ok);
    check("wr_idle", 32'(ok), 32'd1);

    // 5: watchdog abort after 16 cycles, late dtack absorbed
    no_dtack = 1'b1;
    bus.mem_rdata = 8'h77;
    bus.addr[95:72] = 24'h000777;
    bus.req[3] = 1'b1;
    ena_cnt = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (|bus.ack) begin
        ok = 1'b1;
        break;
      end
      if (bus.mem_ena) ena_cnt++;
      if (ena_cnt == 16) force_dtack = 1'b1;
    end
    bus.req[3] = 1'b0;
    check("wd_ack_seen", 32'(ok), 32'd1);
    check("wd_ena_cycles", 32'(ena_cnt), 32'd16);
    check("wd_ack", 32'(bus.ack), 32'b1000);
    check("wd_err", 32'(bus.err), 32'd1);
    check("wd_rdata", 32'(bus.rdata), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wd_absorb_busy", 32'(bus.busy), 32'd1);
      check("wd_absorb_ack", 32'(bus.ack), 32'd0);
      check("wd_absorb_ena", 32'(bus.mem_ena), 32'd0);
    end
    force_dtack = 1'b0;
    no_dtack = 1'b0;
    wait_idle(10, ok);
    check("wd_idle", 32'(ok), 32'd1);
    dly = 2;
    bus.mem_rdata = 8'hC3;
    bus.req[0] = 1'b1;
    wait_ack(40, ok);
    check("wd_next_seen", 32'(ok), 32'd1);
    check("wd_next_ack", 32'(bus.ack), 32'b0001);
    check("wd_next_err", 32'(bus.err), 32'd0);
    check("wd_next_rdata", 32'(bus.rdata), 32'hC3);
    bus.req[0] = 1'b0;
    wait_idle(10, ok);
    check("wd_next_idle", 32'(ok), 32'd1);

    // 6: reset in the middle of ISSUE
    dly = 20;
    bus.req[1] = 1'b1;
    @(negedge clk);
    check("mid_ena", 32'(bus.mem_ena), 32'd1);
    check("mid_grant", 32'(bus.grant_id), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    force_dtack = 1'b1;
    bus.req[1] = 1'b0;
    @(negedge clk);
    check("mid_rst_ena", 32'(bus.mem_ena), 32'd0);
    check("mid_rst_ack", 32'(bus.ack), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_drain_busy", 32'(bus.busy), 32'd1);
      check("mid_drain_ack", 32'(bus.ack), 32'd0);
    end
    force_dtack = 1'b0;
    wait_idle(5, ok);
    check("mid_drain_exit", 32'(ok), 32'd1);
    check("mid_end_ack", 32'(bus.ack), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
